wb_regfile: RTL and testbench

- Consumer end of the MEM/WB control interface: takes RegWriteW/ResultSrcW plus the writeback datapath, selects ResultW and commits it to the 32-entry integer register file.
- Provides the two combinational decode-stage read ports, with same-cycle write-to-read bypass.
- Maintains a 64-bit retired-instruction counter.
- Sits between the MEM/WB pipeline registers and the decode stage.

---
 rtl/wb_regfile_pkg.sv | 18 +
 rtl/wb_regfile_core.sv | 45 ++++
 rtl/wb_regfile.sv | 58 +++++
 tb/tb_wb_regfile.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared writeback and register-file definitions.
// The control decoder that produces ResultSrcD imports this package as well.
package wb_regfile_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned NREGS      = 32;
  localparam int unsigned REG_ADDR_W = $clog2(NREGS);

  localparam logic [REG_ADDR_W-1:0] X0 = REG_ADDR_W'(0);

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_PC4  = 2'b10,
    RES_RSVD = 2'b11
  } resultSrcT;

endpackage

// File: rtl/wb_regfile_core.sv
// Integer register file: x1..x31 with async clear, one write port,
// two combinational read ports with x0 masking and write-to-read bypass.
module regfile_core
  import wb_regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  writeEn,
  input  logic [REG_ADDR_W-1:0] writeAddr,
  input  logic [XLEN-1:0]       writeData,
  input  logic [REG_ADDR_W-1:0] readAddr1,
  input  logic [REG_ADDR_W-1:0] readAddr2,
  output logic [XLEN-1:0]       readData1,
  output logic [XLEN-1:0]       readData2
);

  // x0 has no storage; index 0 is never read from this array
  logic [XLEN-1:0] regs [1:NREGS-1];

  logic doWrite;
  assign doWrite = writeEn && (writeAddr != X0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < int'(NREGS); i++) begin
        regs[i] <= '0;
      end
    end else if (doWrite) begin
      regs[writeAddr] <= writeData;
    end
  end

  // Bypass lets decode see the value being committed on this edge
  always_comb begin
    readData1 = '0;
    readData2 = '0;
    if (readAddr1 != X0) begin
      readData1 = (doWrite && (writeAddr == readAddr1)) ? writeData : regs[readAddr1];
    end
    if (readAddr2 != X0) begin
      readData2 = (doWrite && (writeAddr == readAddr2)) ? writeData : regs[readAddr2];
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage consumer: result select, register-file commit and
// retired-instruction counter.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned CNT_W = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWriteW,
  input  logic [1:0]            ResultSrcW,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic [XLEN-1:0]       ALUResultW,
  input  logic [XLEN-1:0]       ReadDataW,
  input  logic [XLEN-1:0]       PCPlus4W,
  input  logic                  RetireW,
  input  logic [REG_ADDR_W-1:0] A1,
  input  logic [REG_ADDR_W-1:0] A2,
  output logic [XLEN-1:0]       RD1,
  output logic [XLEN-1:0]       RD2,
  output logic [XLEN-1:0]       ResultW,
  output logic [CNT_W-1:0]      InstRet
);

  // Reserved encoding yields zero so a write with it is harmless
  always_comb begin
    ResultW = '0;
    case (resultSrcT'(ResultSrcW))
      RES_ALU:  ResultW = ALUResultW;
      RES_MEM:  ResultW = ReadDataW;
      RES_PC4:  ResultW = PCPlus4W;
      RES_RSVD: ResultW = '0;
      default:  ResultW = '0;
    endcase
  end

  regfile_core uCore (
    .clk       (clk),
    .reset     (reset),
    .writeEn   (RegWriteW),
    .writeAddr (RdW),
    .writeData (ResultW),
    .readAddr1 (A1),
    .readAddr2 (A2),
    .readData1 (RD1),
    .readData2 (RD2)
  );

  // Counts every retired instruction, wrapping silently
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      InstRet <= '0;
    end else if (RetireW) begin
      InstRet <= InstRet + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile; a second narrow-counter instance covers wrap.
module tb_wb_regfile;

  logic        clk;
  logic        reset;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [31:0] PCPlus4W;
  logic        RetireW;
  logic        RetireS;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1, RD2, ResultW;
  logic [31:0] RD1s, RD2s, ResultWs;
  logic [63:0] InstRet;
  logic [3:0]  InstRetS;

  int nCompared;
  int nMismatched;

  wb_regfile dut (
    .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .RdW(RdW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .RetireW(RetireW), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .ResultW(ResultW), .InstRet(InstRet)
  );

  wb_regfile #(.CNT_W(4)) dutSmall (
    .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .RdW(RdW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .RetireW(RetireS), .A1(A1), .A2(A2), .RD1(RD1s), .RD2(RD2s),
    .ResultW(ResultWs), .InstRet(InstRetS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    nCompared++;
    if (RD1 !== 32'h0) begin
      nMismatched++; $display("FAIL reset_rd1_initial: got %h want %h", RD1, 32'h0);
    end
    nCompared++;
    if (InstRet !== 64'h0) begin
      nMismatched++; $display("FAIL reset_instret_initial: got %h want %h", InstRet, 64'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    RegWriteW = 1'b1; ResultSrcW = 2'b00; RdW = 5'd5; ALUResultW = 32'hDEADBEEF; RetireW = 1'b1;
    tick();
    RegWriteW = 1'b0; RetireW = 1'b0; A1 = 5'd5;
    #1;
    nCompared++;
    if (RD1 !== 32'hDEADBEEF) begin
      nMismatched++; $display("FAIL reset_prewrite_x5: got %h want %h", RD1, 32'hDEADBEEF);
    end
    nCompared++;
    if (InstRet !== 64'd1) begin
      nMismatched++; $display("FAIL reset_prewrite_count: got %h want %h", InstRet, 64'd1);
    end
    // mid-cycle async reset, observed before the next edge
    #1 reset = 1'b0;
    #1;
    nCompared++;
    if (RD1 !== 32'h0) begin
      nMismatched++; $display("FAIL reset_async_x5: got %h want %h", RD1, 32'h0);
    end
    nCompared++;
    if (InstRet !== 64'h0) begin
      nMismatched++; $display("FAIL reset_async_count: got %h want %h", InstRet, 64'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_result_select();
    logic [31:0] exp [4];
    exp[0] = 32'h11; exp[1] = 32'h22; exp[2] = 32'h33; exp[3] = 32'h0;
    ALUResultW = 32'h11; ReadDataW = 32'h22; PCPlus4W = 32'h33;
    for (int i = 0; i < 4; i++) begin
      ResultSrcW = 2'(i); RdW = 5'(i + 1); RegWriteW = 1'b1;
      #1;
      nCompared++;
      if (ResultW !== exp[i]) begin
        nMismatched++; $display("FAIL result_sel_%0d: got %h want %h", i, ResultW, exp[i]);
      end
      tick();
    end
    RegWriteW = 1'b0;
    for (int i = 0; i < 4; i++) begin
      A1 = 5'(i + 1); A2 = 5'(4 - i);
      #1;
      nCompared++;
      if (RD1 !== exp[i]) begin
        nMismatched++; $display("FAIL readback_rd1_x%0d: got %h want %h", i + 1, RD1, exp[i]);
      end
      nCompared++;
      if (RD2 !== exp[3 - i]) begin
        nMismatched++; $display("FAIL readback_rd2_x%0d: got %h want %h", 4 - i, RD2, exp[3 - i]);
      end
    end
  endtask

  task automatic test_x0();
    RegWriteW = 1'b1; RdW = 5'd0; ResultSrcW = 2'b00; ALUResultW = 32'hFFFFFFFF;
    A1 = 5'd0; A2 = 5'd0;
    #1;
    nCompared++;
    if (RD1 !== 32'h0) begin
      nMismatched++; $display("FAIL x0_same_cycle: got %h want %h", RD1, 32'h0);
    end
    tick();
    RegWriteW = 1'b0;
    #1;
    nCompared++;
    if (RD1 !== 32'h0) begin
      nMismatched++; $display("FAIL x0_later_rd1: got %h want %h", RD1, 32'h0);
    end
    nCompared++;
    if (RD2 !== 32'h0) begin
      nMismatched++; $display("FAIL x0_later_rd2: got %h want %h", RD2, 32'h0);
    end
  endtask

  task automatic test_bypass();
    RegWriteW = 1'b1; RdW = 5'd7; ResultSrcW = 2'b00; ALUResultW = 32'h100;
    tick();
    ALUResultW = 32'h200; A1 = 5'd7; A2 = 5'd7;
    #1;
    nCompared++;
    if (RD1 !== 32'h200) begin
      nMismatched++; $display("FAIL bypass_rd1: got %h want %h", RD1, 32'h200);
    end
    nCompared++;
    if (RD2 !== 32'h200) begin
      nMismatched++; $display("FAIL bypass_rd2: got %h want %h", RD2, 32'h200);
    end
    A2 = 5'd1;
    #1;
    nCompared++;
    if (RD1 !== 32'h200) begin
      nMismatched++; $display("FAIL bypass_single_rd1: got %h want %h", RD1, 32'h200);
    end
    nCompared++;
    if (RD2 !== 32'h11) begin
      nMismatched++; $display("FAIL bypass_single_rd2: got %h want %h", RD2, 32'h11);
    end
    RegWriteW = 1'b0; A2 = 5'd7;
    #1;
    nCompared++;
    if (RD1 !== 32'h100) begin
      nMismatched++; $display("FAIL nobypass_rd1: got %h want %h", RD1, 32'h100);
    end
    nCompared++;
    if (RD2 !== 32'h100) begin
      nMismatched++; $display("FAIL nobypass_rd2: got %h want %h", RD2, 32'h100);
    end
  endtask

  task automatic test_counter();
    RdW = 5'd8; ALUResultW = 32'h8;
    for (int i = 0; i < 10; i++) begin
      RetireW = 1'b1; RegWriteW = 1'(i % 2);
      tick();
    end
    RetireW = 1'b0; RegWriteW = 1'b0;
    nCompared++;
    if (InstRet !== 64'd10) begin
      nMismatched++; $display("FAIL count_ten: got %0d want %0d", InstRet, 10);
    end
    tick();
    nCompared++;
    if (InstRet !== 64'd10) begin
      nMismatched++; $display("FAIL count_hold: got %0d want %0d", InstRet, 10);
    end
  endtask

  task automatic test_wrap();
    RetireS = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    RetireS = 1'b0;
    nCompared++;
    if (InstRetS !== 4'hF) begin
      nMismatched++; $display("FAIL wrap_max: got %h want %h", InstRetS, 4'hF);
    end
    RetireS = 1'b1;
    tick();
    RetireS = 1'b0;
    nCompared++;
    if (InstRetS !== 4'h0) begin
      nMismatched++; $display("FAIL wrap_zero: got %h want %h", InstRetS, 4'h0);
    end
  endtask

  task automatic test_reset_during_write();
    @(negedge clk);
    RegWriteW = 1'b1; RdW = 5'd9; ResultSrcW = 2'b00; ALUResultW = 32'h999; RetireW = 1'b1;
    @(posedge clk);
    reset = 1'b0;
    #1;
    RegWriteW = 1'b0; RetireW = 1'b0; A1 = 5'd9;
    @(negedge clk);
    reset = 1'b1;
    tick();
    nCompared++;
    if (RD1 !== 32'h0) begin
      nMismatched++; $display("FAIL rst_write_x9: got %h want %h", RD1, 32'h0);
    end
    nCompared++;
    if (InstRet !== 64'h0) begin
      nMismatched++; $display("FAIL rst_write_count: got %h want %h", InstRet, 64'h0);
    end
    RegWriteW = 1'b1; ALUResultW = 32'h55; RetireW = 1'b1;
    tick();
    RegWriteW = 1'b0; RetireW = 1'b0;
    #1;
    nCompared++;
    if (RD1 !== 32'h55) begin
      nMismatched++; $display("FAIL post_release_x9: got %h want %h", RD1, 32'h55);
    end
    nCompared++;
    if (InstRet !== 64'd1) begin
      nMismatched++; $display("FAIL post_release_count: got %h want %h", InstRet, 64'd1);
    end
  endtask

  initial begin
    nCompared = 0; nMismatched = 0;
    reset = 1'b0; RegWriteW = 1'b0; ResultSrcW = 2'b00; RdW = 5'd0;
    ALUResultW = '0; ReadDataW = '0; PCPlus4W = '0;
    RetireW = 1'b0; RetireS = 1'b0; A1 = 5'd5; A2 = 5'd0;
    test_reset();
    test_result_select();
    test_x0();
    test_bypass();
    test_counter();
    test_wrap();
    test_reset_during_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
